// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, field ranges, FSM states and decode helpers
//
// Purpose: constants and helpers shared by the pipeline control logic.
// Ports: none (package).

package cpu_pkg;

  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_BEQ   = 4'hB;
  localparam logic [3:0] OP_NOP   = 4'hE;

  localparam logic [15:0] NOP_INSTR = 16'hE000;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

  // ALU ops (0x0-0x7) and LOAD/STORE/ADDI/BEQ all use rs1.
  function automatic logic reads_rs1(input logic [3:0] op);
    return (op <= OP_BEQ);
  endfunction

  // ALU ops use rs2; STORE uses it as the data register.
  function automatic logic reads_rs2(input logic [3:0] op);
    return (op <= 4'h7) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard comparator
//
// Purpose: flags when the instruction in ID reads the register a LOAD in EX
// is about to write.
// Ports:
//   id_instr   in  16  instruction in ID
//   ex_valid   in  1   EX holds a real instruction
//   ex_is_load in  1   EX instruction is a LOAD
//   ex_rd      in  3   EX destination register
//   load_use   out 1   load-use hazard present

module hazard_detect
  import cpu_pkg::*;
(
  input  logic [15:0] id_instr,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_rd,
  output logic        load_use
);

  logic [3:0] op;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic       unused_bits;

  assign op  = id_instr[OP_HI:OP_LO];
  assign rs1 = id_instr[RS1_HI:RS1_LO];
  assign rs2 = id_instr[RS2_HI:RS2_LO];

  // Destination and immediate fields never take part in the comparison.
  assign unused_bits = ^{id_instr[11:9], id_instr[2:0]};

  // r0 is hard-wired, so a load to r0 can never create a dependency.
  assign load_use = ex_valid && ex_is_load && (ex_rd != 3'd0) &&
                    ((reads_rs1(op) && (rs1 == ex_rd)) ||
                     (reads_rs2(op) && (rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush control with memory watchdog
//
// Purpose: drives stall/flush of PC, IF/ID, ID/EX and EX/MEM from load-use
// hazards, taken branches and the data-memory handshake; counts stall cycles.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_instr            instruction in ID
//   ex_valid/ex_is_load/ex_rd  EX instruction info
//   ex_branch_taken     branch resolved taken in EX
//   mem_req/mem_ready   data-memory handshake
//   stall_pc/stall_id/flush_id/flush_ex/stall_mem  combinational controls
//   mem_err             registered one-cycle watchdog pulse
//   stall_cnt           registered saturating count of stall_pc cycles

module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      id_instr,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_pc,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             stall_mem,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e      state_q;
  logic [WAIT_W-1:0] wait_q;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic             load_use;
  logic             mem_miss;

  hazard_detect u_hazard_detect (
    .id_instr   (id_instr),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  assign mem_miss = mem_req && !mem_ready;

  // Memory freeze outranks branch flush: a branch arriving with a stalled
  // access stays frozen in EX and is flushed once the wait ends.
  always_comb begin
    stall_pc  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    stall_mem = 1'b0;
    if (!rst) begin
      if (state_q == MEM_WAIT || mem_miss) begin
        stall_pc  = 1'b1;
        stall_id  = 1'b1;
        stall_mem = 1'b1;
      end else if (ex_branch_taken) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use) begin
        stall_pc = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  assign stall_cnt_d = (stall_pc && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1
                                                         : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      mem_err_q   <= 1'b0;
      stall_cnt_q <= stall_cnt_d;
      case (state_q)
        RUN: begin
          if (mem_miss) begin
            state_q <= MEM_WAIT;
            wait_q  <= '0;
          end
        end
        MEM_WAIT: begin
          // mem_ready wins over a coincident timeout.
          if (mem_ready) begin
            state_q <= RUN;
            wait_q  <= '0;
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: begin
          state_q <= RUN;
          wait_q  <= '0;
        end
      endcase
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline control for the 16-bit five-stage core. It watches the instruction in ID, the instruction in EX, branch resolution and the data-memory handshake, and drives the stall and flush controls of every pipeline register: PC, IF/ID, ID/EX and EX/MEM. It detects load-use hazards, flushes on taken branches and freezes the pipeline while data memory is busy. A watchdog guards against a hung memory, and a saturating counter records stall cycles for performance monitoring.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 64: maximum number of cycles in `MEM_WAIT` before the watchdog aborts.
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk`  in  1: single clock; everything samples on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `id_instr`  in  16: instruction currently in ID (output of IF/ID).
- `ex_valid`  in  1: EX holds a real instruction (not a bubble).
- `ex_is_load`  in  1: the instruction in EX is a LOAD.
- `ex_rd`  in  3: destination register of the instruction in EX.
- `ex_branch_taken`  in  1: a branch or jump in EX resolved taken this cycle.
- `mem_req`  in  1: MEM stage is issuing a data-memory access this cycle.
- `mem_ready`  in  1: data memory completes the access this cycle.
- `stall_pc`  out  1: hold PC.
- `stall_id`  out  1: hold IF/ID.
- `flush_id`  out  1: load NOP (16'hE000) into IF/ID.
- `flush_ex`  out  1: insert a bubble into ID/EX.
- `stall_mem`  out  1: hold ID/EX and EX/MEM; the MEM/WB valid bit is also cleared.
- `mem_err`  out  1: one-cycle pulse when the watchdog fires.
- `stall_cnt`  out  CNT_W: count of cycles with `stall_pc` high, saturating at all-ones.

## Operation
Instruction decode on `id_instr`:
- opcode is `[15:12]`, rs1 is `[8:6]`, rs2 is `[5:3]`.
- Opcodes 0x0–0x7 read both rs1 and rs2.
- Opcodes 0x8–0xB (LOAD, STORE, ADDI, BEQ) read rs1 only; STORE also reads rs2 (its data register).
- 0xE is NOP and reads nothing. All other opcodes read nothing.

FSM states are `RUN` and `MEM_WAIT`.

In `RUN`, conditions are evaluated in this priority order:
1. If `mem_req && !mem_ready`, go to `MEM_WAIT`. This cycle drives `stall_pc = stall_id = stall_mem = 1` and both flushes 0. A branch seen in the same cycle is frozen in EX and acted on after the wait.
2. Otherwise, if `ex_branch_taken`, drive `flush_id = flush_ex = 1` and no stalls. A load-use hazard in the same cycle is ignored because the ID instruction is wrong-path.
3. Otherwise, on a load-use hazard, drive `stall_pc = stall_id = flush_ex = 1`. The hazard is `ex_valid && ex_is_load && ex_rd != 0` and ID reads a register equal to `ex_rd`. Register r0 never hazards.
4. Otherwise all controls are 0.

In `MEM_WAIT`:
- `stall_pc`, `stall_id` and `stall_mem` are 1; flushes are 0.
- The wait counter increments every cycle.
- On `mem_ready`, the stalls are still asserted that cycle, and the FSM returns to `RUN` next cycle with the counter cleared.
- When the counter reaches `MEM_TIMEOUT-1` without `mem_ready`, the FSM pulses `mem_err` for one cycle, returns to `RUN` and clears the counter. The access is dropped.
- If `mem_ready` and the timeout coincide, `mem_ready` wins and there is no `mem_err`.

`stall_cnt` increments on every cycle where `stall_pc` is 1 and saturates at `2^CNT_W - 1`.

## Timing
- Stall and flush outputs are combinational from the current state and inputs, so they take effect at the same clock edge as the hazard.
- `mem_err` and `stall_cnt` are registered.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 2 killed instructions (IF/ID and ID/EX).
- Reset (including reset asserted mid-`MEM_WAIT`) sets state to `RUN` and clears the wait counter, `stall_cnt` and `mem_err`. While `rst` is high, all combinational outputs are 0.
- Minimum `MEM_WAIT` residency is 1 cycle (the `mem_ready` cycle). Total stall for a k-cycle access equals k.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (`OP_LOAD=4'h8`, `OP_STORE=4'h9`, `OP_NOP=4'hE`, …)
  - `NOP_INSTR=16'hE000`
  - the field bit ranges
  - the FSM state enum
  - `reads_rs1(op)` and `reads_rs2(op)` functions
- One sub-module, `hazard_detect`: a purely combinational load-use comparator (inputs `id_instr`, `ex_valid`, `ex_is_load`, `ex_rd`; output `load_use`).
- The FSM, watchdog and counter stay in the top module.

## Test plan
- **Load-use:** `ex_is_load=1`, `ex_rd=3`, `id_instr=0x1180` (rs1=6, rs2=0) gives no stall. Changing to `id_instr=0x10D8` (rs1=3) gives exactly one cycle of `stall_pc`, `stall_id` and `flush_ex`, and `stall_cnt` advances by 1.
- **r0 exemption:** `ex_rd=0` with ID reading r0 leaves all outputs 0.
- **Branch vs hazard:** `ex_branch_taken=1` together with a load-use hazard gives `flush_id=flush_ex=1` and `stall_pc=0`.
- **Memory wait:** `mem_req=1` with `mem_ready` low for 3 cycles and high on the 4th gives 4 cycles of stalls, FSM back in `RUN` on cycle 5, and `stall_cnt=4`. A branch held in EX flushes on cycle 5.
- **Watchdog:** `MEM_TIMEOUT=8` with `mem_ready` never asserted gives a `mem_err` pulse after 8 cycles and a return to `RUN`. Asserting `mem_ready` on exactly the timeout cycle gives no `mem_err`.
- **Reset and saturation:**
  - Asserting `rst` in `MEM_WAIT` puts the FSM in `RUN` with `stall_cnt=0` on the next cycle.
  - With `CNT_W=4`, 20 stall cycles leave `stall_cnt=15`.
